// File: rtl/tap_ctrl_ir_dr.sv
// tap_ctrl_ir_dr: IEEE 1149.1-style TAP controller with IR, BYPASS, IDCODE and one user DR.
// Latency: shift registers update on each rising clk edge; TDO is combinational from the active LSB.
// Backpressure: none; JTAG is clocked by the host and every edge is accepted.
//
// Ports:
//   clk, TRST        - TCK and synchronous active-high test reset
//   TMS, TDI         - mode select and serial data in
//   TDO, TDO_EN      - serial data out and its enable (high in Shift_DR/Shift_IR)
//   state            - current TAP state (4'd0..4'd15)
//   ir_out           - current instruction
//   user_capture     - parallel value captured into the user shift register
//   user_dr          - user register parallel output
//   user_update      - one-cycle pulse when user_dr is written
module tap_ctrl_ir_dr #(
  parameter int                  IR_WIDTH     = 4,
  parameter int                  DR_WIDTH     = 8,
  parameter logic [31:0]         IDCODE_VAL   = 32'h0BA0_0477,
  parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = 4'h1,
  parameter logic [IR_WIDTH-1:0] INSTR_USER   = 4'h8
) (
  input  logic                clk,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  output logic [3:0]          state,
  output logic [IR_WIDTH-1:0] ir_out,
  input  logic [DR_WIDTH-1:0] user_capture,
  output logic [DR_WIDTH-1:0] user_dr,
  output logic                user_update
);

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_TEST_IDLE    = 4'd1,
    SELECT_DR_SCAN   = 4'd2,
    CAPTURE_DR       = 4'd3,
    SHIFT_DR         = 4'd4,
    EXIT1_DR         = 4'd5,
    PAUSE_DR         = 4'd6,
    EXIT2_DR         = 4'd7,
    UPDATE_DR        = 4'd8,
    SELECT_IR_SCAN   = 4'd9,
    CAPTURE_IR       = 4'd10,
    SHIFT_IR         = 4'd11,
    EXIT1_IR         = 4'd12,
    PAUSE_IR         = 4'd13,
    EXIT2_IR         = 4'd14,
    UPDATE_IR        = 4'd15
  } tap_state_e;

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                byp_q, byp_d;
  logic [31:0]         id_sr_q, id_sr_d;
  logic [DR_WIDTH-1:0] usr_sr_q, usr_sr_d;
  logic [DR_WIDTH-1:0] user_dr_q, user_dr_d;
  logic                upd_q, upd_d;

  logic sel_id;
  logic sel_user;
  logic dr_lsb;

  // Any code other than IDCODE or USER (including all-ones) falls through to BYPASS.
  assign sel_id   = (ir_q == INSTR_IDCODE);
  assign sel_user = (ir_q == INSTR_USER);
  assign dr_lsb   = sel_id ? id_sr_q[0] : (sel_user ? usr_sr_q[0] : byp_q);

  // State register
  always_ff @(posedge clk) begin
    if (TRST) begin
      state_q <= TEST_LOGIC_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: standard 1149.1 TAP graph
  always_comb begin
    state_d = state_q;
    case (state_q)
      TEST_LOGIC_RESET: state_d = TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   state_d = TMS ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       state_d = TMS ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_d = TMS ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_d = TMS ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_d = TMS ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_d = TMS ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_d = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   state_d = TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = TMS ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_d = TMS ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_d = TMS ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_d = TMS ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_d = TMS ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_d = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
  end

  // Datapath next-state: actions are keyed on the state being left at this edge.
  // Pause/Exit states fall through to the hold defaults.
  always_comb begin
    ir_sr_d   = ir_sr_q;
    ir_d      = ir_q;
    byp_d     = byp_q;
    id_sr_d   = id_sr_q;
    usr_sr_d  = usr_sr_q;
    user_dr_d = user_dr_q;
    upd_d     = 1'b0;
    case (state_q)
      TEST_LOGIC_RESET: ir_d = INSTR_IDCODE;
      CAPTURE_IR:       ir_sr_d = {{(IR_WIDTH-1){1'b0}}, 1'b1};
      SHIFT_IR: begin
        ir_sr_d               = ir_sr_q >> 1;
        ir_sr_d[IR_WIDTH-1]   = TDI;
      end
      UPDATE_IR:        ir_d = ir_sr_q;
      CAPTURE_DR: begin
        if (sel_id)        id_sr_d  = IDCODE_VAL;
        else if (sel_user) usr_sr_d = user_capture;
        else               byp_d    = 1'b0;
      end
      SHIFT_DR: begin
        if (sel_id) begin
          id_sr_d     = id_sr_q >> 1;
          id_sr_d[31] = TDI;
        end else if (sel_user) begin
          usr_sr_d             = usr_sr_q >> 1;
          usr_sr_d[DR_WIDTH-1] = TDI;
        end else begin
          byp_d = TDI;
        end
      end
      UPDATE_DR: begin
        if (sel_user) begin
          user_dr_d = usr_sr_q;
          upd_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // TRST wins over every datapath action, including mid-shift.
  always_ff @(posedge clk) begin
    if (TRST) begin
      ir_sr_q   <= '0;
      ir_q      <= INSTR_IDCODE;
      byp_q     <= 1'b0;
      id_sr_q   <= '0;
      usr_sr_q  <= '0;
      user_dr_q <= '0;
      upd_q     <= 1'b0;
    end else begin
      ir_sr_q   <= ir_sr_d;
      ir_q      <= ir_d;
      byp_q     <= byp_d;
      id_sr_q   <= id_sr_d;
      usr_sr_q  <= usr_sr_d;
      user_dr_q <= user_dr_d;
      upd_q     <= upd_d;
    end
  end

  // TDO follows the active chain's LSB through the whole DR or IR column; zero elsewhere.
  always_comb begin
    TDO = 1'b0;
    case (state_q)
      CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR: TDO = dr_lsb;
      CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR: TDO = ir_sr_q[0];
      default: TDO = 1'b0;
    endcase
  end

  assign TDO_EN      = (state_q == SHIFT_DR) || (state_q == SHIFT_IR);
  assign state       = state_q;
  assign ir_out      = ir_q;
  assign user_dr     = user_dr_q;
  assign user_update = upd_q;

endmodule

// File: tb/tb_tap_ctrl_ir_dr.sv
// tb_tap_ctrl_ir_dr: directed bench for tap_ctrl_ir_dr with a TDO/update scoreboard.
// Latency: expected TDO bits are queued ahead of each scan and popped per shift cycle.
// Backpressure: none; the monitor pops whenever TDO_EN or user_update is presented.
module tb_tap_ctrl_ir_dr;

  logic       clk;
  logic       TRST;
  logic       TMS;
  logic       TDI;
  logic       TDO;
  logic       TDO_EN;
  logic [3:0] state;
  logic [3:0] ir_out;
  logic [7:0] user_capture;
  logic [7:0] user_dr;
  logic       user_update;

  int total = 0;
  int bad   = 0;

  logic       tdo_q[$];
  logic [7:0] upd_q[$];
  logic       upd_prev = 1'b0;

  tap_ctrl_ir_dr dut (
    .clk          (clk),
    .TRST         (TRST),
    .TMS          (TMS),
    .TDI          (TDI),
    .TDO          (TDO),
    .TDO_EN       (TDO_EN),
    .state        (state),
    .ir_out       (ir_out),
    .user_capture (user_capture),
    .user_dr      (user_dr),
    .user_update  (user_update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (TDO_EN === 1'b1) begin
      if (tdo_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tdo_unexpected: got TDO_EN=1 expected no shift cycle");
      end else begin
        logic e;
        e = tdo_q.pop_front();
        chk("tdo_bit", 32'(TDO), 32'(e));
      end
    end
    if (user_update === 1'b1) begin
      if (upd_prev) begin
        total++;
        bad++;
        $display("FAIL upd_width: got user_update high 2 cycles expected 1");
      end
      if (upd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL upd_unexpected: got user_update=1 user_dr=%0h expected none", user_dr);
      end else begin
        logic [7:0] e;
        e = upd_q.pop_front();
        chk("upd_val", 32'(user_dr), 32'(e));
      end
    end
    upd_prev = (user_update === 1'b1);
  end

  // One TCK edge with the given TMS/TDI; returns 1 time unit after the rising edge.
  task automatic tck(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) tdo_q.push_back(v[i]);
  endtask

  // Shift n bits LSB-first; the last bit exits to Exit1 when exit_last is set.
  task automatic shift(input logic [31:0] v, input int n, input logic exit_last);
    for (int i = 0; i < n; i++) tck(exit_last && (i == n - 1), v[i]);
  endtask

  // From Run_Test_Idle into Shift_DR / Shift_IR.
  task automatic rti_to_shift_dr();
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  task automatic rti_to_shift_ir();
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  // From Exit1 through Update back to Run_Test_Idle.
  task automatic exit1_to_rti();
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [3:0] code);
    rti_to_shift_ir();
    push_bits(32'h1, 4);
    shift({28'h0, code}, 4, 1'b1);
    exit1_to_rti();
  endtask

  initial begin
    TRST = 1'b1;
    TMS = 1'b0;
    TDI = 1'b0;
    user_capture = 8'h00;
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    TRST = 1'b0;

    // 1. Reset from mid Shift_DR
    tck(1'b0, 1'b0);
    rti_to_shift_dr();
    chk("shdr_state", 32'(state), 32'd4);
    tdo_q.push_back(1'b1);      // IDCODE LSB visible during the one Shift_DR cycle
    TRST = 1'b1;
    tck(1'b0, 1'b1);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ir", 32'(ir_out), 32'h1);
    chk("rst_user_dr", 32'(user_dr), 32'h0);
    chk("rst_tdo_en", 32'(TDO_EN), 32'd0);
    chk("rst_upd", 32'(user_update), 32'd0);
    TRST = 1'b0;
    tck(1'b0, 1'b0);
    chk("rti_state", 32'(state), 32'd1);

    // 2. TMS reset from Pause_IR and from Shift_DR
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    chk("pause_ir_state", 32'(state), 32'd13);
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0);
    chk("tms5_from_pir", 32'(state), 32'd0);
    tck(1'b0, 1'b0);
    rti_to_shift_dr();
    tdo_q.push_back(1'b1);
    for (int i = 0; i < 4; i++) tck(1'b1, 1'b0);
    chk("tms4_from_shdr", 32'(state), 32'd9);
    tck(1'b1, 1'b0);
    chk("tms5_from_shdr", 32'(state), 32'd0);
    chk("tlr_ir", 32'(ir_out), 32'h1);

    // 3. IDCODE readout
    tck(1'b0, 1'b0);
    rti_to_shift_dr();
    push_bits(32'h0BA0_0477, 32);
    shift(32'h0, 32, 1'b1);
    exit1_to_rti();

    // 4. IR load of USER code
    rti_to_shift_ir();
    push_bits(32'h1, 4);
    shift(32'h8, 4, 1'b1);
    tck(1'b1, 1'b0);
    chk("ir_before_upd", 32'(ir_out), 32'h1);
    tck(1'b0, 1'b0);
    chk("ir_after_upd", 32'(ir_out), 32'h8);

    // 5. User DR with a Pause_DR/Exit2_DR detour mid-shift
    user_capture = 8'hC3;
    rti_to_shift_dr();
    push_bits(32'hC3, 8);
    shift(32'hA, 4, 1'b1);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    chk("pause_dr_state", 32'(state), 32'd6);
    chk("pause_dr_tdo_en", 32'(TDO_EN), 32'd0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    shift(32'h5, 4, 1'b1);
    upd_q.push_back(8'h5A);
    tck(1'b1, 1'b0);
    chk("user_dr_pre", 32'(user_dr), 32'h0);
    tck(1'b0, 1'b0);
    chk("user_dr_post", 32'(user_dr), 32'h5A);
    chk("upd_pulse", 32'(user_update), 32'd1);
    tck(1'b0, 1'b0);
    chk("upd_drop", 32'(user_update), 32'd0);

    // 6. BYPASS via all-ones instruction
    load_ir(4'hF);
    chk("ir_bypass", 32'(ir_out), 32'hF);
    user_capture = 8'h3C;
    rti_to_shift_dr();
    push_bits(32'b1010, 4);     // 0,1,0,1 LSB-first: one-bit delay
    shift(32'b1101, 4, 1'b1);   // TDI 1,0,1,1 LSB-first
    exit1_to_rti();
    chk("bypass_user_dr", 32'(user_dr), 32'h5A);
    chk("bypass_ir_hold", 32'(ir_out), 32'hF);

    // TRST clears user_dr and restores IDCODE
    TRST = 1'b1;
    tck(1'b0, 1'b0);
    TRST = 1'b0;
    chk("rst2_user_dr", 32'(user_dr), 32'h0);
    chk("rst2_ir", 32'(ir_out), 32'h1);
    chk("rst2_state", 32'(state), 32'd0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);

    chk("tdo_q_empty", 32'(tdo_q.size()), 32'd0);
    chk("upd_q_empty", 32'(upd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
